weight_rom_fetch: RTL

- Sequencer directly upstream of the conv weight consumer and directly downstream of the weight ROM (`input_weightg`-class IP: 8-bit addr, 144-bit rd_data, fixed read latency).
- On a start command it walks a contiguous address range of the ROM and drives `rom_addr`.
- Each returned 144-bit word is captured into a small first-word-fall-through (FWFT) FIFO and presented to the conv engine on a valid/ready stream.
- Reads are credit-limited, so no returned word is ever dropped under backpressure.

---
 rtl/weight_rom_fetch.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/weight_rom_fetch.sv
// weight_rom_fetch: walks a ROM address range and streams the returned words through a credit-limited FWFT FIFO.
// Optional build macro WEIGHT_FETCH_REPEAT_EN adds repeat_cnt, replaying the range repeat_cnt+1 times back-to-back.

module weight_rom_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 144,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
`ifdef WEIGHT_FETCH_REPEAT_EN
  input  logic [7:0]            repeat_cnt,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int LEN_W  = ADDR_WIDTH + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int USED_W = CNT_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_remaining;
  logic [7:0]            r_rep;
  logic                  r_busy;
  logic                  r_done;
  logic [RD_LATENCY:0]   r_tagValid;
  logic [RD_LATENCY:0]   r_tagLast;
  logic [CNT_W-1:0]      r_inflight;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_lastMem;
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;

  logic [7:0]            w_repeatCnt;
  logic                  w_push;
  logic                  w_pop;
  logic [USED_W-1:0]     w_used;
  logic                  w_canIssue;
  logic                  w_issue;
  logic                  w_issueLast;
  logic [ADDR_WIDTH-1:0] w_nextAddr;
  logic [LEN_W-1:0]      w_nextRemaining;
  logic [7:0]            w_nextRep;
  logic                  w_drainDone;

`ifdef WEIGHT_FETCH_REPEAT_EN
  assign w_repeatCnt = repeat_cnt;
`else
  assign w_repeatCnt = 8'd0;
`endif

  assign m_valid  = (r_count != '0);
  assign m_data   = r_mem[r_rdPtr];
  assign m_last   = m_valid & r_lastMem[r_rdPtr];
  assign rom_addr = r_addr;
  assign busy     = r_busy;
  assign done     = r_done;

  assign w_pop  = m_valid & m_ready;
  assign w_push = r_tagValid[RD_LATENCY];

  // A pop this cycle frees a slot in time for the word being issued now, which keeps 1 word/cycle.
  assign w_used     = {1'b0, r_count} + {1'b0, r_inflight} - USED_W'(w_pop);
  assign w_canIssue = (w_used < USED_W'(FIFO_DEPTH));

  assign w_drainDone = (r_inflight == '0) &&
                       ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop));

  // The first read is issued on the start-accepting edge itself; later ones wait for FIFO credit.
  always_comb begin
    w_issue         = 1'b0;
    w_issueLast     = 1'b0;
    w_nextAddr      = r_addr;
    w_nextRemaining = r_remaining;
    w_nextRep       = r_rep;
    case (r_state)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          w_issue         = 1'b1;
          w_nextAddr      = base_addr;
          w_nextRemaining = len - LEN_W'(1);
          w_nextRep       = w_repeatCnt;
          w_issueLast     = (len == LEN_W'(1)) && (w_repeatCnt == 8'd0);
        end
      end
      ST_FETCH: begin
        if (w_canIssue) begin
          w_issue = 1'b1;
          if (r_remaining != '0) begin
            w_nextAddr      = r_addr + ADDR_WIDTH'(1);
            w_nextRemaining = r_remaining - LEN_W'(1);
            w_issueLast     = (r_remaining == LEN_W'(1)) && (r_rep == 8'd0);
          end else begin
            w_nextAddr      = r_base;
            w_nextRemaining = r_len - LEN_W'(1);
            w_nextRep       = r_rep - 8'd1;
            w_issueLast     = (r_len == LEN_W'(1)) && (r_rep == 8'd1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      r_rep       <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_issue) begin
        r_addr      <= w_nextAddr;
        r_remaining <= w_nextRemaining;
        r_rep       <= w_nextRep;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_base  <= base_addr;
              r_len   <= len;
              r_busy  <= 1'b1;
              r_state <= w_issueLast ? ST_DRAIN : ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (w_issue && w_issueLast) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_drainDone) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tag pipe is one stage longer than the ROM latency because the address itself is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tagValid <= '0;
      r_tagLast  <= '0;
      r_inflight <= '0;
    end else begin
      r_tagValid <= {r_tagValid[RD_LATENCY-1:0], w_issue};
      r_tagLast  <= {r_tagLast[RD_LATENCY-1:0], w_issueLast};
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_lastMem <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr]     <= rom_rd_data;
        r_lastMem[r_wrPtr] <= r_tagLast[RD_LATENCY];
        r_wrPtr            <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  a_noOverflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

endmodule
